cochlea_core_n: RTL
===================

COCHLEA_CORE_N -- requirements
Module: cochlea_core_n

Interface
REQ-001 SHALL have parameter NCH, default 2, number of comparator channels (I, Q, ...); legal range 1..16.
REQ-002 SHALL have parameter GRAY_W, default 10, width of the gray-code time base; legal range 4..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, legal range 2..64.
REQ-004 SHALL have port clk_master, input, 1, the only clock; all flops on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ud_en, input, 1, capture enable; 0 blocks new events.
REQ-007 SHALL have port comp_high, input, NCH, per-channel comparator level from analog.
REQ-008 SHALL have port phi1b_dig, input, NCH, per-channel comparator strobe from analog.
REQ-009 SHALL have port gray_clk, output, GRAY_W, gray-coded time base.
REQ-010 SHALL have port div2out, output, 1, clk_master divided by two.
REQ-011 SHALL have port ev_valid, output, 1, FIFO head valid.
REQ-012 SHALL have port ev_ready, input, 1, consumer accepts head.
REQ-013 SHALL have port ev_chan, output, max(1,clog2(NCH)), channel index of the head event.
REQ-014 SHALL have port ev_pol, output, 1, polarity of the head event.
REQ-015 SHALL have port ev_time, output, GRAY_W, gray timestamp of the head event.
REQ-016 SHALL have port overflow, output, 1, sticky event-lost flag.

Function
REQ-017 SHALL keep a GRAY_W binary counter incrementing every cycle, wrapping from 2^GRAY_W-1 to 0; gray_clk = bin ^ (bin>>1), registered.
REQ-018 SHALL toggle div2out every cycle.
REQ-019 SHALL pass each phi1b_dig and comp_high bit through a 2-flop synchronizer plus a third delay flop on phi1b_dig.
REQ-020 SHALL detect a strobe when synchronized phi1b_dig is 1 and its delayed copy is 0.
REQ-021 SHALL, on a strobe, load per-channel comp_out with synchronized comp_high; an event exists when the new value differs from comp_out; ev polarity = new value.
REQ-022 SHALL ignore events while ud_en=0; comp_out still updates.
REQ-023 SHALL latch an event into a per-channel pending register {pol, gray_clk} at the cycle after detection.
REQ-024 SHALL, when a new event hits a channel whose pending is still set, overwrite pending with the new event and set overflow.
REQ-025 SHALL move at most one pending entry per cycle into the FIFO, chosen round-robin starting after the last granted channel; grant clears that pending bit the same edge.
REQ-026 SHALL not grant while FIFO is full unless a pop occurs in the same cycle.
REQ-027 SHALL pop on a rising edge with ev_valid=1 and ev_ready=1; ev_chan/ev_pol/ev_time SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-028 SHALL present the head first-word-fall-through; a write into an empty FIFO raises ev_valid on the following cycle (no bypass).
REQ-029 SHALL give latency: phi1b_dig rise before edge E0 -> pending set at E2 -> FIFO write at E3 -> ev_valid high after E3 (if no contention, FIFO not full).
REQ-030 SHALL keep overflow set until rst.

Reset
REQ-031 SHALL on rst clear: counter, gray_clk=0, div2out=0, synchronizers, comp_out=0, pending, round-robin pointer=0, FIFO pointers, ev_valid=0, ev_chan/ev_pol/ev_time=0, overflow=0.
REQ-032 SHALL discard in-flight and queued events on rst asserted mid-operation; first post-reset event follows REQ-029 timing.

Configuration
REQ-033 SHALL, with TIMESTAMP_EN defined, store gray_clk per event and drive ev_time from the FIFO.
REQ-034 SHALL, without TIMESTAMP_EN, omit timestamp storage and tie ev_time to 0; all other behaviour unchanged.

Structure
REQ-035 SHALL place FIFO entry layout constants, channel-index width function and parameter limits in shared package cochlea_pkg.
REQ-036 SHALL implement the FIFO as sub-module cochlea_ev_fifo (parametrised width/depth, FWFT, full/empty).

Verification
REQ-037 SHALL cover: NCH=2, ud_en=1, comp_high[0]=1, one phi1b_dig[0] pulse -> one event chan=0 pol=1, ev_valid after E3, ev_time = gray of E2 count.
REQ-038 SHALL cover: both channels strobe same cycle, rr pointer 0 -> chan 1 then chan 0 written on consecutive cycles, no overflow.
REQ-039 SHALL cover: ev_ready=0, 10 events, FIFO_DEPTH=8 -> 8 held, pending stalls, further same-channel event sets overflow=1; ev_ready=1 drains in order.
REQ-040 SHALL cover: counter runs 2^GRAY_W cycles -> gray_clk wraps 0x200 -> 0x000 (GRAY_W=10), single-bit change each cycle.
REQ-041 SHALL cover: ud_en=0 with comparator toggles -> no events; ud_en=1 with unchanged comp_high -> no event.
REQ-042 SHALL cover: rst pulse with 3 queued events -> ev_valid=0 and overflow=0 next cycle, queue empty.

Source files
------------

// File: rtl/cochlea_pkg.sv
// Shared limits, FIFO entry layout and channel-index width for cochlea_core_n.
// Build macro TIMESTAMP_EN adds the gray timestamp field to every FIFO entry.
package cochlea_pkg;

    localparam int NCH_MIN        = 1;
    localparam int NCH_MAX        = 16;
    localparam int GRAY_W_MIN     = 4;
    localparam int GRAY_W_MAX     = 16;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 64;

`ifdef TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Entry layout, LSB first: channel index, polarity, optional timestamp.
    localparam int CHAN_LSB = 0;

    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int pol_bit(input int nch);
        return CHAN_LSB + chan_w(nch);
    endfunction

    function automatic int time_lsb(input int nch);
        return pol_bit(nch) + 1;
    endfunction

    function automatic int entry_w(input int nch, input int gray_w);
        return time_lsb(nch) + (TS_EN ? gray_w : 0);
    endfunction

    function automatic bit params_legal(input int nch, input int gray_w, input int depth);
        return (nch >= NCH_MIN) && (nch <= NCH_MAX) &&
               (gray_w >= GRAY_W_MIN) && (gray_w <= GRAY_W_MAX) &&
               (depth >= FIFO_DEPTH_MIN) && (depth <= FIFO_DEPTH_MAX) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/cochlea_ev_fifo.sv
// First-word-fall-through event FIFO; the head is visible combinationally while not empty.
module cochlea_ev_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_master,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_wr;
    logic         w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd    = i_rd_en & ~o_empty;
    assign w_wr    = i_wr_en & (~o_full | w_rd);

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide whether an entry is live.
    always_ff @(posedge clk_master) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/cochlea_core_n.sv
// Comparator event front-end: synchronise strobes, detect level changes, arbitrate into a FIFO.
// Build macro TIMESTAMP_EN stores the gray time base with each event and drives ev_time.
module cochlea_core_n
    import cochlea_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int GRAY_W     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk_master,
    input  logic                    rst,
    input  logic                    ud_en,
    input  logic [NCH-1:0]          comp_high,
    input  logic [NCH-1:0]          phi1b_dig,
    output logic [GRAY_W-1:0]       gray_clk,
    output logic                    div2out,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [chan_w(NCH)-1:0]  ev_chan,
    output logic                    ev_pol,
    output logic [GRAY_W-1:0]       ev_time,
    output logic                    overflow
);

    localparam int CW  = chan_w(NCH);
    localparam int EW  = entry_w(NCH, GRAY_W);
    localparam int POL = pol_bit(NCH);

    if (!params_legal(NCH, GRAY_W, FIFO_DEPTH)) begin : g_bad_params
        $error("cochlea_core_n: NCH, GRAY_W or FIFO_DEPTH outside legal range");
    end

    logic [GRAY_W-1:0] r_bin;
    logic [GRAY_W-1:0] r_gray;
    logic              r_div2;
    logic [NCH-1:0]    r_phi_s1, r_phi_s2, r_phi_d;
    logic [NCH-1:0]    r_cmp_s1, r_cmp_s2;
    logic [NCH-1:0]    r_comp_out;
    logic [NCH-1:0]    r_pend_v;
    logic [NCH-1:0]    r_pend_pol;
`ifdef TIMESTAMP_EN
    logic [GRAY_W-1:0] r_pend_time [NCH];
`endif
    logic [CW-1:0]     r_rr_ptr;
    logic              r_overflow;

    logic [NCH-1:0]    w_strobe;
    logic [NCH-1:0]    w_event;
    logic [NCH-1:0]    w_grant_oh;
    logic              w_grant_v;
    logic [CW-1:0]     w_grant_idx;
    logic [CW-1:0]     w_cand;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [EW-1:0]     w_wr_data;
    logic [EW-1:0]     w_rd_data;

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_div2 <= 1'b0;
        end else begin
            r_bin  <= r_bin + GRAY_W'(1);
            r_gray <= r_bin ^ (r_bin >> 1);
            r_div2 <= ~r_div2;
        end
    end

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            r_phi_s1   <= '0;
            r_phi_s2   <= '0;
            r_phi_d    <= '0;
            r_cmp_s1   <= '0;
            r_cmp_s2   <= '0;
            r_comp_out <= '0;
        end else begin
            r_phi_s1   <= phi1b_dig;
            r_phi_s2   <= r_phi_s1;
            r_phi_d    <= r_phi_s2;
            r_cmp_s1   <= comp_high;
            r_cmp_s2   <= r_cmp_s1;
            r_comp_out <= (r_comp_out & ~w_strobe) | (r_cmp_s2 & w_strobe);
        end
    end

    // comp_out tracks every strobe; only the event itself is gated by ud_en.
    assign w_strobe = r_phi_s2 & ~r_phi_d;
    assign w_event  = w_strobe & (r_cmp_s2 ^ r_comp_out) & {NCH{ud_en}};
    assign w_pop    = ev_valid & ev_ready;

    // NOTE: defaults come first so no path through the loop leaves a signal unassigned.
    always_comb begin
        w_grant_v   = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (!w_full || w_pop) begin
            for (int i = NCH; i >= 1; i--) begin
                w_cand = CW'((int'(r_rr_ptr) + i) % NCH);
                if (r_pend_v[w_cand]) begin
                    w_grant_v   = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    assign w_grant_oh = w_grant_v ? (NCH'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            r_pend_v   <= '0;
            r_pend_pol <= '0;
`ifdef TIMESTAMP_EN
            for (int i = 0; i < NCH; i++) r_pend_time[i] <= '0;
`endif
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_event[i]) begin
                    r_pend_v[i]    <= 1'b1;
                    r_pend_pol[i]  <= r_cmp_s2[i];
`ifdef TIMESTAMP_EN
                    r_pend_time[i] <= r_gray;
`endif
                end else if (w_grant_oh[i]) begin
                    r_pend_v[i] <= 1'b0;
                end
            end
            if (w_grant_v) r_rr_ptr <= w_grant_idx;
            // A pending entry is lost only if it is not leaving on this same edge.
            r_overflow <= r_overflow | (|(w_event & r_pend_v & ~w_grant_oh));
        end
    end

`ifdef TIMESTAMP_EN
    localparam int TLSB = time_lsb(NCH);
    assign w_wr_data = {r_pend_time[w_grant_idx], r_pend_pol[w_grant_idx], w_grant_idx};
    assign ev_time   = w_rd_data[TLSB +: GRAY_W];
`else
    assign w_wr_data = {r_pend_pol[w_grant_idx], w_grant_idx};
    assign ev_time   = '0;
`endif

    cochlea_ev_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_master (clk_master),
        .rst        (rst),
        .i_wr_en    (w_grant_v),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_rd_data),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign gray_clk = r_gray;
    assign div2out  = r_div2;
    assign ev_valid = ~w_empty;
    assign ev_chan  = w_rd_data[CHAN_LSB +: CW];
    assign ev_pol   = w_rd_data[POL];
    assign overflow = r_overflow;

endmodule
